// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encodings and sizing helpers for uart_frame_codec
package uart_frame_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_HEAD,
      TX_BODY,
      TX_TAIL,
      TX_DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_HUNT,
      RX_HEAD,
      RX_BODY
   } rx_state_t;

   // Width of a length field able to hold 0..max_bytes.
   function automatic int len_w(input int max_bytes);
      return $clog2(max_bytes + 1);
   endfunction

   // Length width for the default 137-byte payload capacity.
   localparam int LEN_W = len_w(137);

   // Inter-byte gap, in sys_clk cycles, that aborts an open receive frame.
   // 64-bit intermediate so fast clocks times long gaps cannot overflow.
   function automatic int timeout_cycles(input int bits, input int clk_freq, input int baud_rate);
      longint t;
      t = longint'(bits) * longint'(clk_freq) / longint'(baud_rate);
      return int'(t);
   endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - byte-level UART receiver, 8N1, mid-bit sampling
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   uart_rx_port       : serial line (asynchronous, synchronised here)
//   rx_tdata, rx_tvalid: received byte with one-cycle valid; bytes with a bad stop bit are dropped
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_rx_port,
   output logic [7:0] rx_tdata,
   output logic       rx_tvalid
);

   localparam int DIV   = CLK_FREQ / BAUD_RATE;
   localparam int HALF  = (DIV / 2 > 0) ? DIV / 2 : 1;
   localparam int CNT_W = $clog2(DIV + 1);

   typedef enum logic [1:0] {P_IDLE, P_START, P_DATA, P_STOP} phase_t;

   phase_t           phase;
   logic             rx_s1, rx_s2;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] baud_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         phase     <= P_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         baud_cnt  <= '0;
         rx_tdata  <= '0;
         rx_tvalid <= 1'b0;
      end else begin
         rx_s1     <= uart_rx_port;
         rx_s2     <= rx_s1;
         rx_tvalid <= 1'b0;
         case (phase)
            P_IDLE: begin
               baud_cnt <= '0;
               if (!rx_s2) phase <= P_START;
            end
            P_START: begin
               // Re-check the line half a bit in to reject glitches.
               if (baud_cnt == CNT_W'(HALF - 1)) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  phase    <= rx_s2 ? P_IDLE : P_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            P_DATA: begin
               if (baud_cnt == CNT_W'(DIV - 1)) begin
                  baud_cnt <= '0;
                  shreg    <= {rx_s2, shreg[7:1]};
                  if (bit_cnt == 3'd7) phase <= P_STOP;
                  else                 bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: begin
               if (baud_cnt == CNT_W'(DIV - 1)) begin
                  baud_cnt <= '0;
                  phase    <= P_IDLE;
                  if (rx_s2) begin
                     rx_tdata  <= shreg;
                     rx_tvalid <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-level UART transmitter, 8N1
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   tx_tdata, tx_tvalid: byte to send; tvalid is a one-cycle request accepted only while idle
//   tx_done            : one-cycle pulse when the stop bit of the byte has completed
//   uart_tx_port       : serial line, idles high
module uart_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] tx_tdata,
   input  logic       tx_tvalid,
   output logic       tx_done,
   output logic       uart_tx_port
);

   localparam int DIV   = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = $clog2(DIV + 1);

   logic [9:0]       shreg;
   logic [3:0]       bit_cnt;
   logic [CNT_W-1:0] baud_cnt;
   logic             active;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shreg    <= '1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         active   <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!active) begin
            if (tx_tvalid) begin
               shreg    <= {1'b1, tx_tdata, 1'b0};
               active   <= 1'b1;
               bit_cnt  <= '0;
               baud_cnt <= '0;
            end
         end else if (baud_cnt == CNT_W'(DIV - 1)) begin
            baud_cnt <= '0;
            // Shift in ones so the line is left high after the stop bit.
            shreg    <= {1'b1, shreg[9:1]};
            if (bit_cnt == 4'd9) begin
               active  <= 1'b0;
               tx_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end
      end
   end

   assign uart_tx_port = shreg[0];

endmodule

// File: rtl/uart_frame_codec.sv
// rtl/uart_frame_codec.sv - delimiter-framed payload transmitter and receiver over a UART line
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   tx_data, tx_len, tx_req   : payload (byte k at [8k+7:8k]), length, start request (sampled in TX_IDLE)
//   tx_busy, tx_done, tx_err  : TX not idle, frame-finished pulse, rejected-request pulse
//   rx_data, rx_len           : last accepted payload and its length, stable between rx_done pulses
//   rx_busy, rx_done, rx_err  : frame open, frame-accepted pulse, overflow/timeout pulse
//   uart_rx_port, uart_tx_port: serial input and output
module uart_frame_codec
   import uart_frame_pkg::*;
#(
   parameter int          CLK_FREQ        = 50_000_000,
   parameter int          BAUD_RATE       = 115_200,
   parameter int          MAX_BYTES       = 137,
   parameter logic [7:0]  DELIM           = 8'h26,
   parameter int          DELIM_CNT       = 2,
   parameter int          RX_TIMEOUT_BITS = 40,
   localparam int         LEN_W           = uart_frame_pkg::len_w(MAX_BYTES)
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [8*MAX_BYTES-1:0] tx_data,
   input  logic [LEN_W-1:0]       tx_len,
   input  logic                   tx_req,
   output logic                   tx_busy,
   output logic                   tx_done,
   output logic                   tx_err,
   output logic [8*MAX_BYTES-1:0] rx_data,
   output logic [LEN_W-1:0]       rx_len,
   output logic                   rx_busy,
   output logic                   rx_done,
   output logic                   rx_err,
   input  logic                   uart_rx_port,
   output logic                   uart_tx_port
);

   localparam int               CNT_W      = (LEN_W > 2) ? LEN_W : 2;
   localparam int               PW         = LEN_W + 2;
   localparam int               TO_CYCLES  = timeout_cycles(RX_TIMEOUT_BITS, CLK_FREQ, BAUD_RATE);
   localparam int               TO_W       = $clog2(TO_CYCLES + 1);
   localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] DC_LAST    = CNT_W'(DELIM_CNT - 1);
   localparam logic [2:0]       DC3        = 3'(DELIM_CNT);

   // ---------------------------------------------------------------- TX path
   tx_state_t              tx_state, tx_next;
   logic [CNT_W-1:0]       tx_cnt;
   logic                   tx_inflight;
   logic [8*MAX_BYTES-1:0] tx_buf;
   logic [LEN_W-1:0]       tx_len_q;
   logic                   tb_valid, tb_done;
   logic [7:0]             tb_data;

   uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart_tx (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .tx_tdata     (tb_data),
      .tx_tvalid    (tb_valid),
      .tx_done      (tb_done),
      .uart_tx_port (uart_tx_port)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) tx_state <= TX_IDLE;
      else            tx_state <= tx_next;
   end

   // tx_cnt counts delimiter bytes in HEAD/TAIL and is the payload index in BODY.
   // A byte is requested only while none is in flight, giving one request per byte.
   always_comb begin
      tx_next  = tx_state;
      tb_valid = 1'b0;
      tb_data  = DELIM;
      case (tx_state)
         TX_IDLE: begin
            if (tx_req && (tx_len <= MAX_LEN)) tx_next = TX_HEAD;
         end
         TX_HEAD: begin
            tb_valid = !tx_inflight;
            if (tb_done && (tx_cnt == DC_LAST))
               tx_next = (tx_len_q == '0) ? TX_TAIL : TX_BODY;
         end
         TX_BODY: begin
            tb_valid = !tx_inflight;
            tb_data  = 8'(tx_buf >> {tx_cnt, 3'b000});
            if (tb_done && ((tx_cnt + CNT_W'(1)) == CNT_W'(tx_len_q)))
               tx_next = TX_TAIL;
         end
         TX_TAIL: begin
            tb_valid = !tx_inflight;
            if (tb_done && (tx_cnt == DC_LAST)) tx_next = TX_DONE;
         end
         TX_DONE: tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_cnt      <= '0;
         tx_inflight <= 1'b0;
         tx_buf      <= '0;
         tx_len_q    <= '0;
         tx_err      <= 1'b0;
      end else begin
         tx_err <= (tx_state == TX_IDLE) && tx_req && (tx_len > MAX_LEN);
         if ((tx_state == TX_IDLE) && tx_req) begin
            tx_buf   <= tx_data;
            tx_len_q <= tx_len;
         end
         if (tx_next != tx_state) tx_cnt <= '0;
         else if (tb_done)        tx_cnt <= tx_cnt + CNT_W'(1);
         if (tb_valid)     tx_inflight <= 1'b1;
         else if (tb_done) tx_inflight <= 1'b0;
      end
   end

   assign tx_busy = (tx_state != TX_IDLE);
   assign tx_done = (tx_state == TX_DONE);

   // ---------------------------------------------------------------- RX path
   rx_state_t              rx_state, rx_next, eff_state;
   logic [1:0]             run_cnt, run_next;
   logic [LEN_W-1:0]       wr_idx, wr_idx_next;
   logic [8*MAX_BYTES-1:0] shadow;
   logic [TO_W-1:0]        idle_cnt;
   logic                   rb_valid;
   logic [7:0]             rb_data;
   logic                   is_delim, run_full, timed_out;
   logic                   rx_close, rx_fail, rx_wr;
   logic [PW-1:0]          wr_pos, commit_len;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart_rx (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .uart_rx_port (uart_rx_port),
      .rx_tdata     (rb_data),
      .rx_tvalid    (rb_valid)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rx_state <= RX_HUNT;
      else            rx_state <= rx_next;
   end

   // Delimiters inside the body are written to the shadow buffer speculatively
   // at wr_idx+run_cnt; wr_idx only advances when a non-delimiter commits the
   // run, so a closing run never becomes part of the payload length.
   always_comb begin
      rx_next     = rx_state;
      run_next    = run_cnt;
      wr_idx_next = wr_idx;
      rx_close    = 1'b0;
      rx_fail     = 1'b0;
      rx_wr       = 1'b0;
      is_delim    = (rb_data == DELIM);
      run_full    = (({1'b0, run_cnt} + 3'd1) == DC3);
      wr_pos      = PW'(wr_idx) + PW'(run_cnt);
      commit_len  = wr_pos + PW'(1);
      timed_out   = (rx_state != RX_HUNT) && (idle_cnt == TO_W'(TO_CYCLES));
      // A byte landing in the timeout cycle is judged as if already hunting.
      eff_state   = timed_out ? RX_HUNT : rx_state;
      if (timed_out) begin
         rx_fail  = 1'b1;
         rx_next  = RX_HUNT;
         run_next = '0;
      end
      if (rb_valid) begin
         case (eff_state)
            RX_HUNT: begin
               if (is_delim) begin
                  wr_idx_next = '0;
                  if (DELIM_CNT == 1) begin
                     rx_next  = RX_BODY;
                     run_next = '0;
                  end else begin
                     rx_next  = RX_HEAD;
                     run_next = 2'd1;
                  end
               end
            end
            RX_HEAD: begin
               if (!is_delim) begin
                  rx_next  = RX_HUNT;
                  run_next = '0;
               end else if (run_full) begin
                  rx_next     = RX_BODY;
                  run_next    = '0;
                  wr_idx_next = '0;
               end else begin
                  run_next = run_cnt + 2'd1;
               end
            end
            RX_BODY: begin
               if (is_delim) begin
                  if (run_full) begin
                     rx_close = 1'b1;
                     rx_next  = RX_HUNT;
                     run_next = '0;
                  end else begin
                     rx_wr    = 1'b1;
                     run_next = run_cnt + 2'd1;
                  end
               end else if (commit_len > PW'(MAX_BYTES)) begin
                  rx_fail  = 1'b1;
                  rx_next  = RX_HUNT;
                  run_next = '0;
               end else begin
                  rx_wr       = 1'b1;
                  wr_idx_next = LEN_W'(commit_len);
                  run_next    = '0;
               end
            end
            default: begin
               rx_next  = RX_HUNT;
               run_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_cnt  <= '0;
         wr_idx   <= '0;
         shadow   <= '0;
         idle_cnt <= '0;
         rx_data  <= '0;
         rx_len   <= '0;
         rx_done  <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         run_cnt <= run_next;
         wr_idx  <= wr_idx_next;
         rx_done <= rx_close;
         rx_err  <= rx_fail;
         if (rx_wr && (wr_pos < PW'(MAX_BYTES)))
            shadow[{wr_pos, 3'b000} +: 8] <= rb_data;
         if (rx_close) begin
            rx_data <= shadow;
            rx_len  <= wr_idx;
         end
         if (rb_valid || (rx_next == RX_HUNT)) idle_cnt <= '0;
         else                                  idle_cnt <= idle_cnt + TO_W'(1);
      end
   end

   assign rx_busy = (rx_state != RX_HUNT);

endmodule

// File: tb/tb_uart_frame_codec.sv
// tb/tb_uart_frame_codec.sv - self-checking bench for uart_frame_codec
module tb_uart_frame_codec;

   localparam int         CLK_FREQ  = 1_000_000;
   localparam int         BAUD_RATE = 100_000;
   localparam int         MAX_BYTES = 16;
   localparam logic [7:0] DELIM     = 8'h26;
   localparam int         DELIM_CNT = 2;
   localparam int         TO_BITS   = 40;
   localparam int         DIV       = CLK_FREQ / BAUD_RATE;
   localparam int         LEN_W     = $clog2(MAX_BYTES + 1);

   typedef logic [7:0] byte_q_t[$];

   logic                   sys_clk = 1'b0;
   logic                   sys_rst_n = 1'b0;
   logic [8*MAX_BYTES-1:0] tx_data = '0;
   logic [LEN_W-1:0]       tx_len = '0;
   logic                   tx_req = 1'b0;
   logic                   tx_busy, tx_done, tx_err;
   logic [8*MAX_BYTES-1:0] rx_data;
   logic [LEN_W-1:0]       rx_len;
   logic                   rx_busy, rx_done, rx_err;
   logic                   uart_rx_port, uart_tx_port;
   logic                   rx_line = 1'b1;
   logic                   loop_en = 1'b0;

   assign uart_rx_port = loop_en ? uart_tx_port : rx_line;

   always #5 sys_clk = ~sys_clk;

   uart_frame_codec #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .MAX_BYTES(MAX_BYTES),
      .DELIM(DELIM), .DELIM_CNT(DELIM_CNT), .RX_TIMEOUT_BITS(TO_BITS)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .tx_data(tx_data), .tx_len(tx_len), .tx_req(tx_req),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
      .rx_data(rx_data), .rx_len(rx_len),
      .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err),
      .uart_rx_port(uart_rx_port), .uart_tx_port(uart_tx_port)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_tx_done = 0, n_tx_err = 0, n_rx_done = 0, n_rx_err = 0;
   logic [7:0] line_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge sys_clk) begin
      if (tx_done) n_tx_done++;
      if (tx_err)  n_tx_err++;
      if (rx_done) n_rx_done++;
      if (rx_err)  n_rx_err++;
   end

   // Independent line decoder: samples each bit in its middle.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge uart_tx_port);
         repeat (DIV + DIV / 2) @(negedge sys_clk);
         for (int i = 0; i < 8; i++) begin
            b[i] = uart_tx_port;
            if (i < 7) repeat (DIV) @(negedge sys_clk);
         end
         repeat (DIV) @(negedge sys_clk);
         line_q.push_back(b);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge sys_clk) rx_line = 1'b0;
      repeat (DIV) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (DIV) @(negedge sys_clk);
      end
      rx_line = 1'b1;
      repeat (DIV) @(negedge sys_clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic start_tx(input byte_q_t p, input int len);
      @(negedge sys_clk);
      tx_data = '0;
      for (int i = 0; i < p.size() && i < MAX_BYTES; i++) tx_data[8*i +: 8] = p[i];
      tx_len = LEN_W'(len);
      tx_req = 1'b1;
      @(negedge sys_clk) tx_req = 1'b0;
   endtask

   task automatic wait_tx_done(input string tag, input int budget);
      int n = 0;
      while (!tx_done && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check(tag, 32'(tx_done), 32'd1);
   endtask

   task automatic wait_rx_done(input string tag, input int budget);
      int n = 0;
      while (!rx_done && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check(tag, 32'(rx_done), 32'd1);
   endtask

   function automatic byte_q_t rand_payload(input int len);
      byte_q_t p;
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == DELIM) b = 8'h5a;
         p.push_back(b);
      end
      return p;
   endfunction

   // Reference framing: header run, payload verbatim, trailer run.
   function automatic byte_q_t frame_of(input byte_q_t p);
      byte_q_t f;
      for (int i = 0; i < DELIM_CNT; i++) f.push_back(DELIM);
      foreach (p[i]) f.push_back(p[i]);
      for (int i = 0; i < DELIM_CNT; i++) f.push_back(DELIM);
      return f;
   endfunction

   task automatic run_tx(input string tag, input byte_q_t p);
      byte_q_t exp;
      int d0;
      exp = frame_of(p);
      line_q.delete();
      d0 = n_tx_done;
      start_tx(p, p.size());
      wait_tx_done({tag, "_done"}, (exp.size() + 2) * 10 * DIV + 50);
      check({tag, "_busy_at_done"}, 32'(tx_busy), 32'd1);
      @(negedge sys_clk);
      check({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
      repeat (2 * DIV) @(negedge sys_clk);
      check({tag, "_line_len"}, 32'(line_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < line_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(line_q[i]), 32'(exp[i]));
      check({tag, "_done_cnt"}, 32'(n_tx_done - d0), 32'd1);
   endtask

   task automatic check_rx_bytes(input string tag, input byte_q_t p);
      check({tag, "_len"}, 32'(rx_len), 32'(p.size()));
      foreach (p[i]) check($sformatf("%s_b%0d", tag, i), 32'(rx_data[8*i +: 8]), 32'(p[i]));
   endtask

   initial begin
      byte_q_t p, abc;
      int d0, e0, t0, f0;
      string zs;

      repeat (5) @(negedge sys_clk);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_rx_busy", 32'(rx_busy), 32'd0);
      check("rst_line", 32'(uart_tx_port), 32'd1);
      check("rst_rx_len", 32'(rx_len), 32'd0);
      check("rst_rx_data", 32'(rx_data != '0), 32'd0);
      check("rst_pulses", 32'({tx_done, tx_err, rx_done, rx_err}), 32'd0);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      abc = {8'h61, 8'h62, 8'h63};
      run_tx("tx_abc", abc);
      p = {};
      run_tx("tx_len0", p);

      line_q.delete();
      e0 = n_tx_err;
      start_tx(abc, MAX_BYTES + 1);
      repeat (30 * DIV) @(negedge sys_clk);
      check("tx_over_err", 32'(n_tx_err - e0), 32'd1);
      check("tx_over_line", 32'(line_q.size()), 32'd0);
      check("tx_over_busy", 32'(tx_busy), 32'd0);
      check("tx_over_idle", 32'(uart_tx_port), 32'd1);

      for (int k = 0; k < 3; k++) begin
         p = rand_payload($urandom_range(1, MAX_BYTES));
         run_tx($sformatf("tx_rand%0d", k), p);
      end

      d0 = n_rx_done;
      send_str("x&&a&b&&");
      repeat (3 * DIV) @(negedge sys_clk);
      check("rx_basic_done", 32'(n_rx_done - d0), 32'd1);
      check_rx_bytes("rx_basic", {8'h61, DELIM, 8'h62});

      d0 = n_rx_done;
      e0 = n_rx_err;
      zs = "&&";
      for (int i = 0; i < MAX_BYTES + 1; i++) zs = {zs, "z"};
      send_str(zs);
      repeat (3 * DIV) @(negedge sys_clk);
      check("rx_ovf_err", 32'(n_rx_err - e0), 32'd1);
      check("rx_ovf_nodone", 32'(n_rx_done - d0), 32'd0);
      check_rx_bytes("rx_ovf_keep", {8'h61, DELIM, 8'h62});

      e0 = n_rx_err;
      send_str("&&ab");
      repeat (50 * DIV) @(negedge sys_clk);
      check("rx_to_err", 32'(n_rx_err - e0), 32'd1);
      check("rx_to_busy", 32'(rx_busy), 32'd0);
      d0 = n_rx_done;
      send_str("&&q&&");
      repeat (3 * DIV) @(negedge sys_clk);
      check("rx_after_to_done", 32'(n_rx_done - d0), 32'd1);
      check_rx_bytes("rx_after_to", {8'h71});

      p = rand_payload(5);
      start_tx(p, 5);
      send_str("&&");
      @(negedge sys_clk) rx_line = 1'b0;
      repeat (3 * DIV) @(negedge sys_clk);
      check("mid_tx_busy", 32'(tx_busy), 32'd1);
      check("mid_rx_busy", 32'(rx_busy), 32'd1);
      d0 = n_rx_done; e0 = n_rx_err; t0 = n_tx_done; f0 = n_tx_err;
      sys_rst_n = 1'b0;
      rx_line = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("mrst_tx_busy", 32'(tx_busy), 32'd0);
      check("mrst_rx_busy", 32'(rx_busy), 32'd0);
      check("mrst_line", 32'(uart_tx_port), 32'd1);
      check("mrst_rx_len", 32'(rx_len), 32'd0);
      check("mrst_rx_data", 32'(rx_data != '0), 32'd0);
      check("mrst_pulses", 32'({tx_done, tx_err, rx_done, rx_err}), 32'd0);
      sys_rst_n = 1'b1;
      repeat (60 * DIV) @(negedge sys_clk);
      check("mrst_no_pulses", 32'((n_rx_done - d0) + (n_rx_err - e0) + (n_tx_done - t0) + (n_tx_err - f0)), 32'd0);
      check("mrst_idle", 32'({tx_busy, rx_busy}), 32'd0);
      line_q.delete();

      loop_en = 1'b1;
      p = rand_payload($urandom_range(1, MAX_BYTES));
      start_tx(p, p.size());
      wait_rx_done("loop_rx_done", (p.size() + 6) * 10 * DIV);
      @(negedge sys_clk);
      check_rx_bytes("loop", p);
      wait_tx_done("loop_tx_done", 20 * DIV);
      repeat (DIV) @(negedge sys_clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
